// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: FSM state encoding and the default width
// for the arithmetic blocks.
package arith_pkg;

  localparam int ARITH_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/full_subtractor_bit.sv
// Combinational 1-bit full subtractor cell: d = x - y - bi, with bo the borrow-out.
// Used by the bit-serial subtractor, and usable as the cell of a ripple subtractor.
module full_subtractor_bit (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor {bout, diff} = a - b - bin, LSB first, with a start/busy/done handshake.
// Define SERIAL_SUB_SIGNED_OVF_EN to build the signed-overflow flag; otherwise ovf is tied to 0.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_next;
  logic             borrow_q;
  logic [CW-1:0]    cnt_q;
  logic             done_q, bout_q;
  logic [WIDTH-1:0] diff_q;
  logic             bit_d, bit_bo;

  full_subtractor_bit u_cell (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .bi (borrow_q),
    .d  (bit_d),
    .bo (bit_bo)
  );

  // New difference bit enters at the MSB so that after WIDTH shifts the LSB sits at bit 0.
  assign res_next = WIDTH'({bit_d, res_sr} >> 1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (cnt_q == CNT_LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_sr     <= a;
            b_sr     <= b;
            borrow_q <= bin;
            cnt_q    <= '0;
          end
        end
        S_SHIFT: begin
          a_sr     <= a_sr >> 1;
          b_sr     <= b_sr >> 1;
          res_sr   <= res_next;
          borrow_q <= bit_bo;
          cnt_q    <= cnt_q + CW'(1);
        end
        S_DONE: begin
          done_q <= 1'b1;
          diff_q <= res_sr;
          bout_q <= borrow_q;
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic a_msb_q, b_msb_q, ovf_q;

  // Operand MSBs are kept aside because the shift registers no longer hold them by DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (state_q == S_IDLE && start) begin
        a_msb_q <= a[WIDTH-1];
        b_msb_q <= b[WIDTH-1];
      end
      if (state_q == S_DONE)
        ovf_q <= (a_msb_q != b_msb_q) && (res_sr[WIDTH-1] != a_msb_q);
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=4): reference model from plain integer
// arithmetic, with handshake noise, reset abort, exhaustive and random operand sweeps.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         bin = 1'b0;
  logic         busy, done, bout, ovf;
  logic [W-1:0] diff;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    int           start_edge;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int done_cnt = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                 input logic ibin, input int se);
    exp_t e;
    int full, sa, sbv, sr;
    full = int'(ia) - int'(ib) - int'(ibin);
    e.diff = W'((full + (1 << W)) % (1 << W));
    e.bout = (full < 0);
    sa  = (int'(ia) >= (1 << (W-1))) ? int'(ia) - (1 << W) : int'(ia);
    sbv = (int'(ib) >= (1 << (W-1))) ? int'(ib) - (1 << W) : int'(ib);
    sr  = sa - sbv - int'(ibin);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    e.ovf = (sr < -(1 << (W-1))) || (sr > (1 << (W-1)) - 1);
`else
    e.ovf = 1'b0;
`endif
    e.start_edge = se;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("diff", int'(diff), int'(e.diff));
        chk("bout", int'(bout), int'(e.bout));
        chk("ovf", int'(ovf), int'(e.ovf));
        chk("latency", edge_cnt - e.start_edge, W + 1);
      end
    end
  end

  // mode 0: clean pulse; 1: random start noise and operand churn while busy;
  // 2: start held high throughout with operands changed mid-operation.
  task automatic op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                    input int mode);
    @(negedge clk);
    a = ia; b = ib; bin = ibin; start = 1'b1;
    sb.push_back(model(ia, ib, ibin, edge_cnt + 1));
    for (int k = 0; k <= W + 1; k++) begin
      @(negedge clk);
      chk("busy", int'(busy), (k <= W) ? 1 : 0);
      if (k <= W && mode == 1) start = 1'($urandom_range(0, 1));
      else if (k <= W && mode == 2) start = 1'b1;
      else start = 1'b0;
      if (mode != 0) begin
        a = W'($urandom_range(0, (1 << W) - 1));
        b = W'($urandom_range(0, (1 << W) - 1));
        bin = 1'($urandom_range(0, 1));
      end
    end
    #1;
    chk("done_seen", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_diff", int'(diff), 0);
    chk("rst_bout", int'(bout), 0);
    chk("rst_ovf", int'(ovf), 0);
    rst_n = 1'b1;

    op(4'd5, 4'd3, 1'b0, 0);
    op(4'd3, 4'd5, 1'b0, 0);
    op(4'd0, 4'd0, 1'b1, 0);
    op(4'd15, 4'd15, 1'b1, 0);

    snap = done_cnt;
    op(4'd6, 4'd2, 1'b1, 2);
    repeat (6) @(negedge clk);
    chk("held_start_dones", done_cnt - snap, 1);
    op(4'd12, 4'd7, 1'b0, 0);

    // Reset during the second SHIFT cycle of an operation.
    op(4'd15, 4'd15, 1'b1, 0);
    snap = done_cnt;
    @(negedge clk);
    a = 4'd9; b = 4'd1; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_diff", int'(diff), 0);
    chk("abort_bout", int'(bout), 0);
    chk("abort_ovf", int'(ovf), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_no_done", done_cnt - snap, 0);
    op(4'd9, 4'd4, 1'b0, 0);

    op(4'd8, 4'd1, 1'b0, 0);
    op(4'd7, 4'd15, 1'b0, 0);
    op(4'd5, 4'd3, 1'b0, 0);

    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      op(v[8:5], v[4:1], v[0], 0);
    end

    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      op(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
         1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
